// File: rtl/gpio_int_pkg.sv
// gpio_int_pkg: shared defaults and encodings for the GPIO interrupt generator
package gpio_int_pkg;
    localparam int PORT_W_DEF = 16;
    localparam int DB_CNT_DEF = 4;
    localparam int CNT_W = 4;
    localparam logic INT_EDGE = 1'b1;
    localparam logic INT_LEVEL = 1'b0;
endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-pin 2-flop synchroniser with optional debounce (GPIO_DEBOUNCE_EN)
module gpio_in_filter
    import gpio_int_pkg::*;
#(
    parameter int DB_CNT = DB_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    if (DB_CNT < 2 || DB_CNT > 15) begin : g_bad_db_cnt
        $error("DB_CNT out of range 2..15");
    end
    logic [1:0] sync;
    // two-stage synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else sync <= {sync[0], din};
    end
`ifdef GPIO_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt;
    logic q;
    // accept a new value only after it differs from the output for DB_CNT cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            q <= 1'b0;
        end else if (sync[1] == q) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DB_CNT - 1)) begin
            cnt <= '0;
            q <= sync[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    assign dout = q;
`else
    assign dout = sync[1];
`endif
endmodule

// File: rtl/gpio_int_gen.sv
// gpio_int_gen: per-pin edge/level interrupt status with W1C clear; GPIO_DEBOUNCE_EN adds input debounce
module gpio_int_gen
    import gpio_int_pkg::*;
#(
    parameter int PORT_W = PORT_W_DEF,
    parameter int DB_CNT = DB_CNT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PORT_W-1:0] portin,
    input  logic [PORT_W-1:0] inten,
    input  logic [PORT_W-1:0] inttype,
    input  logic [PORT_W-1:0] intpol,
    input  logic [PORT_W-1:0] intclr,
    output logic [PORT_W-1:0] datain,
    output logic [PORT_W-1:0] gpioint,
    output logic              combint
);
    logic [PORT_W-1:0] prev, hit, evt, keep, nxt;
    genvar i;
    for (i = 0; i < PORT_W; i++) begin : g_pin
        gpio_in_filter #(.DB_CNT(DB_CNT)) u_filt (
            .clk(clk),
            .rst(rst),
            .din(portin[i]),
            .dout(datain[i])
        );
    end
    // previous pin value for edge detection
    always_ff @(posedge clk) begin
        if (rst) prev <= '0;
        else prev <= datain;
    end
    // events, set-over-clear, and level-mode clear blocking
    always_comb begin
        hit = ~(datain ^ intpol);
        evt = '0;
        keep = '0;
        nxt = '0;
        for (int b = 0; b < PORT_W; b++) begin
            evt[b] = hit[b] && (inttype[b] == INT_LEVEL || prev[b] != datain[b]);
            keep[b] = hit[b] && inttype[b] == INT_LEVEL;
            nxt[b] = (evt[b] && inten[b]) || (gpioint[b] && !(intclr[b] && !keep[b]));
        end
    end
    // registered interrupt status
    always_ff @(posedge clk) begin
        if (rst) gpioint <= '0;
        else gpioint <= nxt;
    end
    assign combint = |gpioint;
endmodule

// File: tb/tb_gpio_int_gen.sv
// tb_gpio_int_gen: table-driven plus directed checks for gpio_int_gen (default build)
module tb_gpio_int_gen;
    logic clk = 1'b0;
    logic rst;
    logic [15:0] portin, inten, inttype, intpol, intclr;
    logic [15:0] datain, gpioint;
    logic combint;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pin, en, typ, pol, clr;
        int cyc;
        logic [15:0] e_dat, e_int;
    } vec_t;

    vec_t vecs [9];

    gpio_int_gen dut (
        .clk(clk),
        .rst(rst),
        .portin(portin),
        .inten(inten),
        .inttype(inttype),
        .intpol(intpol),
        .intclr(intclr),
        .datain(datain),
        .gpioint(gpioint),
        .combint(combint)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] e_dat, input logic [15:0] e_int);
        chk({name, ".datain"}, datain, e_dat);
        chk({name, ".gpioint"}, gpioint, e_int);
        chk({name, ".combint"}, {15'b0, combint}, {15'b0, |e_int});
    endtask

    initial begin
        logic [15:0] v, h;
        vecs[0] = '{16'h0000, 16'h0009, 16'h0008, 16'h0008, 16'h0000, 1, 16'h0000, 16'h0001};
        vecs[1] = '{16'h0000, 16'h0009, 16'h0008, 16'h0008, 16'h0001, 1, 16'h0000, 16'h0001};
        vecs[2] = '{16'h0009, 16'h0009, 16'h0008, 16'h0008, 16'h0000, 1, 16'h0000, 16'h0001};
        vecs[3] = '{16'h0009, 16'h0009, 16'h0008, 16'h0008, 16'h0000, 1, 16'h0009, 16'h0001};
        vecs[4] = '{16'h0009, 16'h0009, 16'h0008, 16'h0008, 16'h0000, 1, 16'h0009, 16'h0009};
        vecs[5] = '{16'h0009, 16'h0009, 16'h0008, 16'h0008, 16'h0001, 1, 16'h0009, 16'h0008};
        vecs[6] = '{16'h0009, 16'h0009, 16'h0008, 16'h0008, 16'h0008, 1, 16'h0009, 16'h0000};
        vecs[7] = '{16'hFFFF, 16'h0000, 16'h0008, 16'h0008, 16'h0000, 2, 16'hFFFF, 16'h0000};
        vecs[8] = '{16'h0000, 16'h0000, 16'h0008, 16'h0008, 16'h0000, 2, 16'h0000, 16'h0000};

        rst = 1'b1;
        portin = '0; inten = '0; inttype = '0; intpol = '0; intclr = '0;
        step(2);
        chk_all("reset", 16'h0000, 16'h0000);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            portin = vecs[k].pin;
            inten = vecs[k].en;
            inttype = vecs[k].typ;
            intpol = vecs[k].pol;
            intclr = vecs[k].clr;
            step(1);
            intclr = '0;
            if (vecs[k].cyc > 1) step(vecs[k].cyc - 1);
            chk_all($sformatf("vec%0d", k), vecs[k].e_dat, vecs[k].e_int);
        end

        h = 16'h0000;
        for (int k = 0; k < 20; k++) begin
            v = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
            portin = v;
            step(1);
            chk_all($sformatf("toggle%0d", k), h, 16'h0000);
            h = v;
        end

        portin = 16'h0080;
        step(2);
        chk("coll.rise_dat", datain, 16'h0080);
        inten = 16'h0080; inttype = 16'h0080; intpol = 16'h0000;
        step(1);
        chk("coll.no_rise_int", gpioint, 16'h0000);
        portin = 16'h0000;
        step(2);
        chk("coll.fall_dat", datain, 16'h0000);
        intclr = 16'h0080;
        step(1);
        intclr = '0;
        chk("coll.set_wins", gpioint, 16'h0080);
        step(1);
        chk("coll.hold", gpioint, 16'h0080);
        intclr = 16'h0080;
        step(1);
        intclr = '0;
        chk("coll.cleared", gpioint, 16'h0000);

        inten = 16'h00F0; inttype = 16'h0000; intpol = 16'h00F0; portin = 16'h00F0;
        step(3);
        chk_all("lvlhi", 16'h00F0, 16'h00F0);
        inten = 16'h0000; intpol = 16'h0000;
        step(1);
        chk("lvlhi.cfg_keep", gpioint, 16'h00F0);

        inten = 16'h0001; inttype = 16'h0001; intpol = 16'h0001; portin = 16'h0001;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_all("midrst", 16'h0000, 16'h0000);
        step(2);
        chk_all("midrst.r2", 16'h0001, 16'h0000);
        step(1);
        chk_all("midrst.r3", 16'h0001, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpio_int_gen.md
GPIO_INT_GEN -- requirements
Module: gpio_int_gen

Interface
REQ-001 Parameter PORT_W, default 16: number of GPIO pins.
REQ-002 Parameter DB_CNT, default 4: debounce stability count in clk cycles; legal range 2..15.
REQ-003 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port portin  input  PORT_W: asynchronous pin inputs.
REQ-006 Port inten  input  PORT_W: per-pin interrupt enable.
REQ-007 Port inttype  input  PORT_W: per-pin mode; 1 = edge, 0 = level.
REQ-008 Port intpol  input  PORT_W: per-pin polarity; 1 = rising/high, 0 = falling/low.
REQ-009 Port intclr  input  PORT_W: single-cycle write-1-to-clear pulse for status bits.
REQ-010 Port datain  output  PORT_W: synchronised, and optionally filtered, pin value for register read-back.
REQ-011 Port gpioint  output  PORT_W: per-pin interrupt status, registered.
REQ-012 Port combint  output  1: OR-reduction of gpioint.

Function
REQ-013 The block shall pass portin through a 2-flop synchroniser per bit; datain shall equal the synchroniser output (or the filter output, per REQ-029).
REQ-014 Latency: a portin change set up before edge k shall appear on datain after edge k+1 and on gpioint after edge k+2.
REQ-015 The block shall hold a prev register per bit that captures datain every cycle.
REQ-016 Edge event, per bit: inttype=1 and (intpol=1: prev=0, datain=1 | intpol=0: prev=1, datain=0).
REQ-017 Level event, per bit: inttype=0 and datain==intpol.
REQ-018 The status bit shall set on the cycle after an event when inten=1.
REQ-019 An event with inten=0 shall not set status.
REQ-020 Clearing inten shall not clear an already-set status bit.
REQ-021 In edge mode, a status bit shall hold until intclr for that bit is 1, then clear on the next edge.
REQ-022 In level mode, intclr shall clear status only if the level event is absent that cycle; otherwise status stays 1.
REQ-023 If set and clear occur together, set shall win.
REQ-024 Changing inttype or intpol shall not modify existing status; new events use the new settings from the next cycle.
REQ-025 combint shall be combinational OR of gpioint, so it carries no added latency.
REQ-026 Pin pulses shorter than one clk cycle may be missed; this is not an error.

Reset
REQ-027 While rst=1 at a clk edge, the block shall clear synchroniser flops, prev, filter state, and status to 0, giving datain=0, gpioint=0, combint=0.
REQ-028 After rst deasserts, a pin already high shall generate a rising-edge event, if enabled, once it propagates; this is intended behaviour.

Configuration
REQ-029 With GPIO_DEBOUNCE_EN defined, each bit shall have a 4-bit stability counter. datain updates to the synchroniser value only after that value has differed from datain for DB_CNT consecutive cycles. The counter restarts on any bounce. REQ-014 latency increases by DB_CNT cycles.
REQ-030 Without GPIO_DEBOUNCE_EN, no counter logic shall exist and datain shall be the synchroniser output.

Structure
REQ-031 Package gpio_int_pkg shall hold the PORT_W and DB_CNT defaults, the INT_EDGE/INT_LEVEL encoding constants, and the counter-width constant.
REQ-032 The per-bit synchroniser plus debounce shall be sub-module gpio_in_filter, instantiated PORT_W times via generate.

Verification
REQ-033 Rising edge: inten[3]=1, inttype[3]=1, intpol[3]=1; portin[3] 0->1 before edge k -> gpioint[3]=1 and combint=1 after edge k+2; intclr[3] pulse -> gpioint[3]=0 next cycle.
REQ-034 Level low: inttype[0]=0, intpol[0]=0, inten[0]=1, portin[0]=0 held -> gpioint[0] stays 1 despite intclr[0]; after portin[0]=1 propagates, an intclr pulse clears it.
REQ-035 Disabled pin: inten=16'h0000, toggle portin=16'hFFFF/16'h0000 ten times -> gpioint=0, combint=0 throughout; datain follows portin with 2-cycle lag.
REQ-036 Set/clear collision: a falling event on bit 7 in the same cycle as intclr[7]=1 -> gpioint[7] remains 1.
REQ-037 Reset mid-operation: gpioint=16'h00F0, then assert rst one cycle -> gpioint=0, datain=0 next edge; with portin=16'h0001 and bit 0 rising-enabled, gpioint[0] reasserts 3 cycles after rst release.
REQ-038 With GPIO_DEBOUNCE_EN and DB_CNT=4: a 3-cycle glitch on portin[5] -> datain[5] unchanged, no interrupt; a 6-cycle pulse -> datain[5] follows and gpioint[5] sets.
